// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified IF/MEM memory arbiter: FSM encoding,
// owner ids, full byte-enable mask and the saturating streak helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [3:0] BE_ALL = 4'b1111;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STREAK_W = 4;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] val,
                                                  input logic [STREAK_W-1:0] lim);
    return (val >= lim) ? lim : val + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters, with the data-side
// streak that bounds how long a pending fetch can be starved.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                dm_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_dm_o,
  output logic [STREAK_W-1:0] streak_nxt_o
);

  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_MAX);

  logic grant_dm_c;

  // Data wins ties until the streak limit is reached, then fetch is forced.
  always_comb begin
    grant_dm_c   = dm_req_i & (~if_req_i | (streak_i != LIM));
    streak_nxt_o = '0;
    if (grant_dm_c && if_req_i) begin
      streak_nxt_o = sat_inc(streak_i, LIM);
    end
    grant_dm_o = grant_dm_c;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// load/store, sequencing each access through IDLE/ISSUE/WAIT/DONE.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              busy
);

  logic [1:0]          state_q,     state_d;
  logic                owner_q,     owner_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q,    mem_be_d;
  logic [31:0]         if_rdata_q,  if_rdata_d;
  logic [31:0]         dm_rdata_q,  dm_rdata_d;
  logic                if_ack_q,    if_ack_d;
  logic                dm_ack_q,    dm_ack_d;

  logic                grant_dm;
  logic [STREAK_W-1:0] streak_nxt;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .streak_i     (streak_q),
    .grant_dm_o   (grant_dm),
    .streak_nxt_o (streak_nxt)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_d     = ST_ISSUE;
          owner_d     = grant_dm ? OWN_DM : OWN_IF;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dm & dm_we;
          mem_addr_d  = grant_dm ? dm_addr : if_addr;
          mem_wdata_d = grant_dm ? dm_wdata : 32'h0;
          mem_be_d    = (grant_dm && dm_we) ? dm_be : BE_ALL;
          streak_d    = streak_nxt;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Count down to the cycle in which mem_rdata is valid.
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DM) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;

  assign stall_if = if_req & ~if_ack_q;
  assign stall_dm = dm_req & ~dm_ack_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It arbitrates between the two requesters and sequences each memory access through an issue/wait/respond state machine. It returns read data with a one-cycle ack pulse, and generates the stall signals that gate PC/IF-ID writes and freeze the MEM stage. Data-side priority is bounded by a starvation limit so fetch always makes progress.

Parameters:
ADDR_W, 10, word-address width (byte address bits [ADDR_W+1:2])
MEM_LAT, 2, memory read latency in cycles from mem_en cycle to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, max consecutive DM grants made while if_req is pending before IF is forced; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch word address
if_rdata  out  32  fetched instruction; valid in the if_ack cycle
if_ack  out  1  one-cycle completion pulse
dm_req  in  1  data request; held with the fields below until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  32  store data
dm_be  in  4  store byte enables (from SaveType decode)
dm_rdata  out  32  load data; valid in the dm_ack cycle
dm_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory command strobe, exactly one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables (4'b1111 for fetch and load)
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_if  out  1  if_req & ~if_ack (combinational from registered ack)
stall_dm  out  1  dm_req & ~dm_ack
busy  out  1  state != IDLE

Behaviour:
- Reset values: all mem_* = 0, if_ack = dm_ack = 0, if_rdata = dm_rdata = 0, state = IDLE, streak = 0, owner = IF.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any request is present, select a winner and register its command into mem_* and owner; go to ISSUE. With no request, stay in IDLE.
- ISSUE (1 cycle): mem_en = 1 with registered mem_we/addr/wdata/be. Load the counter with MEM_LAT-1; go to WAIT.
- WAIT: decrement the counter. When the counter = 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to DONE.
- DONE (1 cycle): the owner's ack = 1. The owner's req is ignored this cycle (stale hold). The other requester's req is also not granted until IDLE.
- Latency: with a request first seen in IDLE cycle R, mem_en is high in R+1, mem_rdata is sampled in R+1+MEM_LAT, and ack is high in R+2+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Stores: same timing as loads; dm_rdata retains its previous value.
- mem_* hold their values outside ISSUE; mem_en = 0 outside ISSUE.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: DM wins unless streak == STARVE_MAX, in which case IF wins.
- Streak update:
  - DM grant with if_req = 1: streak++ (saturating at STARVE_MAX).
  - IF grant: streak = 0.
  - DM grant with if_req = 0: streak = 0.
- Requester drops req mid-transaction (branch flush): the access still completes and ack still pulses; the requester ignores it. No cancellation.
- Request asserted during DONE by the non-owner: granted from the following IDLE cycle.
- rst mid-transaction: return to IDLE next edge and drive all outputs to reset values. The in-flight response is discarded (no ack). A store already issued may have been committed by memory.
- Address width: mem_addr = selected addr verbatim; no wrap logic (memory decodes ADDR_W bits).

Decomposition:
- Shared package (mem_arb_pkg):
  - state encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE (2 bits)
  - owner constants OWN_IF = 0, OWN_DM = 1
  - BE_ALL = 4'b1111
- Sub-module mem_arb_pick: combinational winner select plus next-streak computation (inputs if_req, dm_req, streak; outputs grant_dm, streak_nxt). The FSM, counter, and registers stay in the top.

Test Plan:
- IF-only fetch, addr 0x004, memory returns 0x20080005, MEM_LAT = 2, req at cycle 0 -> mem_en at cycle 1 with addr 0x004 and be = 1111; if_ack and if_rdata = 0x20080005 at cycle 4; stall_if high in cycles 0–3.
- Simultaneous if_req and dm_req (load 0x010) in IDLE -> DM granted first (dm_ack at cycle 4), IF granted at cycle 5 (if_ack at cycle 9); no mem_en overlap.
- dm_req held continuously with STARVE_MAX = 4 and if_req high -> 4 DM grants, then the 5th grant goes to IF; streak clears and the pattern repeats.
- Store dm_we = 1, addr 0x020, wdata 0xDEADBEEF, be = 0011 -> mem_en cycle shows we = 1, addr, wdata, and be exactly; dm_ack at cycle 4; dm_rdata unchanged.
- if_req dropped at cycle 2 of a fetch -> if_ack still pulses at cycle 4; no second mem_en is issued for IF.
- rst asserted in the WAIT cycle -> next cycle busy = 0, no ack pulses, all outputs 0; a new if_req afterwards completes normally with MEM_LAT+2 latency.
